// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchronizer, start validation at mid-bit,
// CPU read handshake and error flags. Parity bit enabled by macro UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_uart,
    input  logic                 clr,
    input  logic                 baud_tick,
    input  logic                 rxd,
    input  logic                 rdn,
    output logic [DATA_BITS-1:0] r_data,
    output logic                 r_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 sampling
);
    localparam int CNT_W = $clog2(OVERSAMPLE + 1);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd4;

    if (DATA_BITS < 5 || DATA_BITS > 8 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
        (OVERSAMPLE % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_param: illegal parameter value");
    end

    logic                 r_sync1, r_sync2, r_prev, r_fall_pend;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_rxd_s, w_fall, w_start, w_half, w_full;

`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    logic r_par_bit, r_par_err, w_par_err;
    assign w_par_err    = ((^r_shift) ^ r_par_bit) != (PARITY_ODD != 0);
    assign parity_error = r_par_err;
`else
    assign parity_error = 1'b0;
`endif

    assign w_rxd_s  = r_sync2;
    assign w_fall   = r_prev & ~w_rxd_s;
    // An edge that coincided with the stop sample is remembered for one cycle.
    assign w_start  = ~w_rxd_s & (r_prev | r_fall_pend);
    assign w_half   = (r_cnt == HALF_LAST);
    assign w_full   = (r_cnt == FULL_LAST);
    assign sampling = (r_state != S_IDLE);

    always_ff @(posedge clk_uart) begin
        if (clr) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_prev      <= 1'b1;
            r_fall_pend <= 1'b0;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_ready     <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_sync1     <= rxd;
            r_sync2     <= r_sync1;
            r_prev      <= w_rxd_s;
            r_fall_pend <= 1'b0;
            // A CPU read clears the flags; a stop sample later in this block overrides it.
            if (!rdn) begin
                r_ready     <= 1'b0;
                frame_error <= 1'b0;
                overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_par_err   <= 1'b0;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        r_cnt <= w_half ? '0 : r_cnt + 1'b1;
                        r_bit <= '0;
                        if (w_half)
                            r_state <= w_rxd_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        r_cnt <= w_full ? '0 : r_cnt + 1'b1;
                        if (w_full) begin
                            r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                            r_bit   <= r_bit + 1'b1;
                            if (r_bit == BITS_LAST)
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_tick) begin
                        r_cnt <= w_full ? '0 : r_cnt + 1'b1;
                        if (w_full) begin
                            r_par_bit <= w_rxd_s;
                            r_state   <= S_STOP;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (baud_tick) begin
                        r_cnt <= w_full ? '0 : r_cnt + 1'b1;
                        if (w_full) begin
                            r_state     <= S_IDLE;
                            r_fall_pend <= w_fall;
                            r_data      <= r_shift;
                            r_ready     <= 1'b1;
                            frame_error <= ~w_rxd_s;
                            overrun     <= r_ready & rdn;
`ifdef UART_RX_PARITY_EN
                            r_par_err   <= w_par_err;
`endif
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8-bit/16x instance plus 5-bit/8x instance.
// Parity scenarios follow UART_RX_PARITY_EN when it is defined for the whole build.
module tb_uart_rx_param;
    localparam int BIT8 = 32;  // 16 ticks per bit, one tick every 2 clocks
    localparam int BIT5 = 16;  // 8 ticks per bit

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic baud_tick = 1'b0;
    logic clr = 1'b1, rxd8 = 1'b1, rdn8 = 1'b1;
    logic clr5 = 1'b1, rxd5 = 1'b1, rdn5 = 1'b1;
    logic [7:0] d8;
    logic [4:0] d5;
    logic rdy8, pe8, fe8, ov8, smp8;
    logic rdy5, pe5, fe5, ov5, smp5;

    exp_t q8[$];
    exp_t q5[$];
    bit   model_rdy8 = 1'b0, model_rdy5 = 1'b0;
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;
    always @(negedge clk) baud_tick = ~baud_tick;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(0)) dut (
        .clk_uart(clk), .clr(clr), .baud_tick(baud_tick), .rxd(rxd8), .rdn(rdn8),
        .r_data(d8), .r_ready(rdy8), .parity_error(pe8), .frame_error(fe8),
        .overrun(ov8), .sampling(smp8)
    );

    uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(8), .PARITY_ODD(0)) dut5 (
        .clk_uart(clk), .clr(clr5), .baud_tick(baud_tick), .rxd(rxd5), .rdn(rdn5),
        .r_data(d5), .r_ready(rdy5), .parity_error(pe5), .frame_error(fe5),
        .overrun(ov5), .sampling(smp5)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit five, input logic v);
        if (five) rxd5 = v; else rxd8 = v;
    endtask

    // Sends one frame and pushes its expected outcome. With rd_at_stop, rdn8 is held low
    // through the stop bit until r_ready is seen set again (the load must beat the clear).
    task automatic send_frame(input bit five, input logic [7:0] d, input logic stop_v,
                              input logic pbit, input bit rd_at_stop, output bit saw);
        int nb, bc;
        exp_t e;
        logic [7:0] dm;
        nb  = five ? 5 : 8;
        bc  = five ? BIT5 : BIT8;
        dm  = five ? (d & 8'h1F) : d;
        saw = 1'b0;
        e.data = dm;
        e.fe   = ~stop_v;
`ifdef UART_RX_PARITY_EN
        e.pe   = (^dm) ^ pbit;
`else
        e.pe   = 1'b0;
`endif
        e.ov = rd_at_stop ? 1'b0 : (five ? model_rdy5 : model_rdy8);
        if (five) begin q5.push_back(e); model_rdy5 = 1'b1; end
        else begin q8.push_back(e); model_rdy8 = 1'b1; end
        drive(five, 1'b0);
        tick(bc);
        for (int i = 0; i < nb; i++) begin
            drive(five, d[i]);
            tick(bc);
        end
`ifdef UART_RX_PARITY_EN
        drive(five, pbit);
        tick(bc);
`endif
        drive(five, stop_v);
        if (rd_at_stop) begin
            rdn8 = 1'b0;
            for (int k = 0; k < bc; k++) begin
                tick(1);
                if (k >= 2 && rdn8 == 1'b0 && rdy8 === 1'b1) begin
                    rdn8 = 1'b1;
                    saw  = 1'b1;
                end
            end
            rdn8 = 1'b1;
        end else begin
            tick(bc);
        end
        drive(five, 1'b1);
        if (!stop_v) tick(bc);
        tick(4);
    endtask

    task automatic pop(input bit five, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        if (five && q5.size() > 0) begin e = q5.pop_front(); ok = 1'b1; end
        if (!five && q8.size() > 0) begin e = q8.pop_front(); ok = 1'b1; end
    endtask

    task automatic read8();
        rdn8 = 1'b0;
        tick(1);
        rdn8 = 1'b1;
        model_rdy8 = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        clr = 1'b1; clr5 = 1'b1;
        tick(3);
        checks++;
        if (d8 !== 8'h00) begin failures++; $display("FAIL reset_data8 got=%h exp=00", d8); end
        checks++;
        if ({rdy8, pe8, fe8, ov8, smp8} !== 5'b0) begin
            failures++; $display("FAIL reset_flags8 got=%b exp=00000", {rdy8, pe8, fe8, ov8, smp8});
        end
        checks++;
        if ({d5, rdy5, pe5, fe5, ov5, smp5} !== 10'b0) begin
            failures++; $display("FAIL reset_dut5 got=%b exp=0", {d5, rdy5, pe5, fe5, ov5, smp5});
        end
        clr = 1'b0; clr5 = 1'b0;
        tick(6);
    endtask

    task automatic test_basic();
        exp_t e; bit ok, saw;
        send_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, saw);
        pop(1'b0, e, ok);
        checks++;
        if (!ok || d8 !== e.data) begin failures++; $display("FAIL basic_data got=%h exp=%h", d8, e.data); end
        checks++;
        if ({rdy8, pe8, fe8, ov8} !== {1'b1, e.pe, e.fe, e.ov}) begin
            failures++; $display("FAIL basic_flags got=%b exp=%b", {rdy8, pe8, fe8, ov8}, {1'b1, e.pe, e.fe, e.ov});
        end
        read8();
        checks++;
        if (rdy8 !== 1'b0 || d8 !== e.data) begin
            failures++; $display("FAIL basic_read got rdy=%b data=%h exp rdy=0 data=%h", rdy8, d8, e.data);
        end
        $display("basic: data=%h rdy=%b fe=%b ov=%b", d8, rdy8, fe8, ov8);
    endtask

    task automatic test_glitch();
        bit saw_smp;
        saw_smp = 1'b0;
        rxd8 = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(1); saw_smp |= smp8; end
        rxd8 = 1'b1;
        for (int i = 0; i < 60; i++) begin tick(1); saw_smp |= smp8; end
        checks++;
        if (saw_smp !== 1'b1) begin failures++; $display("FAIL glitch_sampling_pulse got=%b exp=1", saw_smp); end
        checks++;
        if ({smp8, rdy8} !== 2'b00) begin
            failures++; $display("FAIL glitch_idle got smp/rdy=%b exp=00", {smp8, rdy8});
        end
        $display("glitch: sampling pulsed=%b now=%b rdy=%b", saw_smp, smp8, rdy8);
    endtask

    task automatic test_frame_error();
        exp_t e; bit ok, saw;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, saw);
        pop(1'b0, e, ok);
        checks++;
        if (!ok || d8 !== e.data || {rdy8, fe8, ov8} !== {1'b1, e.fe, e.ov}) begin
            failures++; $display("FAIL frame_error got data=%h rdy/fe/ov=%b exp data=%h rdy/fe/ov=%b",
                                 d8, {rdy8, fe8, ov8}, e.data, {1'b1, e.fe, e.ov});
        end
        $display("frame_error: data=%h fe=%b rdy=%b", d8, fe8, rdy8);
        read8();
    endtask

    task automatic test_back_to_back();
        exp_t e; bit ok, saw;
        send_frame(1'b0, 8'h11, 1'b1, 1'b0, 1'b0, saw);
        pop(1'b0, e, ok);
        checks++;
        if (!ok || d8 !== e.data || {rdy8, ov8} !== {1'b1, e.ov}) begin
            failures++; $display("FAIL b2b_first got data=%h rdy/ov=%b exp data=%h rdy/ov=%b", d8, {rdy8, ov8}, e.data, {1'b1, e.ov});
        end
        send_frame(1'b0, 8'h22, 1'b1, 1'b0, 1'b0, saw);
        pop(1'b0, e, ok);
        checks++;
        if (!ok || d8 !== e.data || {rdy8, ov8} !== {1'b1, e.ov}) begin
            failures++; $display("FAIL b2b_overrun got data=%h rdy/ov=%b exp data=%h rdy/ov=%b", d8, {rdy8, ov8}, e.data, {1'b1, e.ov});
        end
        $display("back_to_back: data=%h ov=%b", d8, ov8);
        read8();
        checks++;
        if ({rdy8, pe8, fe8, ov8} !== 4'b0 || d8 !== e.data) begin
            failures++; $display("FAIL b2b_read got flags=%b data=%h exp flags=0000 data=%h", {rdy8, pe8, fe8, ov8}, d8, e.data);
        end
    endtask

    task automatic test_read_collision();
        exp_t e; bit ok, saw;
        send_frame(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, saw);
        pop(1'b0, e, ok);
        send_frame(1'b0, 8'h66, 1'b1, 1'b0, 1'b1, saw);
        pop(1'b0, e, ok);
        checks++;
        if (saw !== 1'b1) begin failures++; $display("FAIL collision_load_wins got=%b exp=1", saw); end
        checks++;
        if (!ok || d8 !== e.data || {rdy8, fe8, ov8} !== {1'b1, e.fe, e.ov}) begin
            failures++; $display("FAIL collision_state got data=%h rdy/fe/ov=%b exp data=%h rdy/fe/ov=%b",
                                 d8, {rdy8, fe8, ov8}, e.data, {1'b1, e.fe, e.ov});
        end
        $display("collision: data=%h rdy=%b ov=%b", d8, rdy8, ov8);
        read8();
    endtask

    task automatic test_parity();
        exp_t e; bit ok, saw;
        for (int p = 0; p < 2; p++) begin
            send_frame(1'b0, 8'h07, 1'b1, p[0], 1'b0, saw);
            pop(1'b0, e, ok);
            checks++;
            if (!ok || d8 !== e.data || pe8 !== e.pe) begin
                failures++; $display("FAIL parity_pbit%0d got data=%h pe=%b exp data=%h pe=%b", p, d8, pe8, e.data, e.pe);
            end
            $display("parity: pbit=%0d data=%h pe=%b", p, d8, pe8);
            read8();
        end
    endtask

    task automatic test_clr_midframe();
        exp_t e; bit ok, saw;
        rxd5 = 1'b0; tick(BIT5);
        rxd5 = 1'b1; tick(2 * BIT5 + BIT5 / 2);
        clr5 = 1'b1;
        tick(3);
        checks++;
        if ({d5, rdy5, pe5, fe5, ov5, smp5} !== 10'b0) begin
            failures++; $display("FAIL clr_abort got=%b exp=0", {d5, rdy5, pe5, fe5, ov5, smp5});
        end
        clr5 = 1'b0;
        tick(4 * BIT5);
        checks++;
        if ({rdy5, smp5} !== 2'b00) begin failures++; $display("FAIL clr_no_resume got rdy/smp=%b exp=00", {rdy5, smp5}); end
        send_frame(1'b1, 8'h15, 1'b1, 1'b0, 1'b0, saw);
        pop(1'b1, e, ok);
        checks++;
        if (!ok || d5 !== e.data[4:0] || {rdy5, pe5, fe5, ov5} !== {1'b1, e.pe, e.fe, e.ov}) begin
            failures++; $display("FAIL clr_resume got data=%h flags=%b exp data=%h flags=%b",
                                 d5, {rdy5, pe5, fe5, ov5}, e.data[4:0], {1'b1, e.pe, e.fe, e.ov});
        end
        checks++;
        if (q5.size() != 0 || q8.size() != 0) begin
            failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", q5.size() + q8.size());
        end
        $display("clr_midframe: data5=%h rdy5=%b", d5, rdy5);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_read_collision();
        test_parity();
        test_clr_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
